// File: rtl/serial_word_shifter_pkg.sv
// Shared definitions for the parallel-to-serial word shifter.
package serial_word_shifter_pkg;

    // Shifter FSM states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Width of the completed-word counter
    localparam int WC_W = 16;

    // Bit-counter width; kept at least one bit wide so WIDTH=2 still has a usable counter
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_word_shifter_hold_buf.sv
// One-entry holding register with a valid flag. A word is written on load and
// released on take; the two never coincide because the writer only loads while empty.
module word_hold_buf
    import serial_word_shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             take,
    output logic [WIDTH-1:0] hold_data,
    output logic             hold_valid
);

    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;

    // Per-bit data capture on load; contents are only meaningful while valid
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_data
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    data_reg[gi] <= 1'b0;
                else if (load)
                    data_reg[gi] <= load_data[gi];
            end
        end
    endgenerate

    // Valid flag: set by load, cleared by take
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            valid_reg <= 1'b0;
        else if (load)
            valid_reg <= 1'b1;
        else if (take)
            valid_reg <= 1'b0;
    end

    assign hold_data  = data_reg;
    assign hold_valid = valid_reg;

endmodule

// File: rtl/serial_word_shifter.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and emits
// them one bit per enabled cycle. A one-entry holding buffer lets words stream back
// to back with no idle bit in between.
module serial_word_shifter
    import serial_word_shifter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ser_en,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy,
    output logic [WC_W-1:0]  word_count
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t            state_reg;
    logic [WIDTH-1:0]  sh_reg;
    logic [WIDTH-1:0]  sh_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [WC_W-1:0]   word_count_reg;
    logic              cnt_last;
    logic              hold_load;
    logic              hold_take;
    logic [WIDTH-1:0]  hold_data;
    logic              hold_valid;
    logic              out_bit;

    assign cnt_last  = (cnt_reg == CNT_LAST);
    // Ready comes straight from the registered buffer flag, never from in_valid
    assign in_ready  = ~hold_valid;
    assign hold_load = in_valid & ~hold_valid;
    // The buffer drains when idle, or on the last bit of the current word
    assign hold_take = hold_valid & ((state_reg == ST_IDLE) |
                                     ((state_reg == ST_SHIFT) & ser_en & cnt_last));

    word_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk        (clk),
        .reset      (reset),
        .load       (hold_load),
        .load_data  (in_data),
        .take       (hold_take),
        .hold_data  (hold_data),
        .hold_valid (hold_valid)
    );

    // Shift direction and output tap follow the bit order
    generate
        if (MSB_FIRST) begin : g_msb
            assign sh_next = {sh_reg[WIDTH-2:0], 1'b0};
            assign out_bit = sh_reg[WIDTH-1];
        end else begin : g_lsb
            assign sh_next = {1'b0, sh_reg[WIDTH-1:1]};
            assign out_bit = sh_reg[0];
        end
    endgenerate

    // FSM with shifter, bit counter and completed-word counter; ser_en=0 freezes SHIFT
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            sh_reg         <= '0;
            cnt_reg        <= '0;
            word_count_reg <= '0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (hold_valid) begin
                        sh_reg    <= hold_data;
                        cnt_reg   <= '0;
                        state_reg <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (ser_en) begin
                        if (cnt_last) begin
                            word_count_reg <= word_count_reg + 1'b1;
                            cnt_reg        <= '0;
                            if (hold_valid)
                                sh_reg <= hold_data;
                            else
                                state_reg <= ST_IDLE;
                        end else begin
                            sh_reg  <= sh_next;
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign ser_valid  = (state_reg == ST_SHIFT) & ser_en;
    assign ser_bit    = (state_reg == ST_IDLE) ? IDLE_BIT : out_bit;
    assign ser_first  = ser_valid & (cnt_reg == '0);
    assign ser_last   = ser_valid & cnt_last;
    assign busy       = (state_reg == ST_SHIFT) | hold_valid;
    assign word_count = word_count_reg;

endmodule

// File: tb/tb_serial_word_shifter.sv
// Bench for serial_word_shifter: an MSB-first and an LSB-first instance share one
// stimulus stream and are checked every cycle against a word-level queue model.
module tb_serial_word_shifter;

    localparam int W = 8;
    localparam bit IDLE_B = 1'b0;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         ser_en = 1'b0;

    logic        rdy_m, bit_m, val_m, first_m, last_m, busy_m;
    logic [15:0] wc_m;
    logic        rdy_l, bit_l, val_l, first_l, last_l, busy_l;
    logic [15:0] wc_l;

    serial_word_shifter #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE_B)) dut_msb (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_m),
        .ser_en(ser_en), .ser_bit(bit_m), .ser_valid(val_m), .ser_first(first_m),
        .ser_last(last_m), .busy(busy_m), .word_count(wc_m)
    );

    serial_word_shifter #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE_B)) dut_lsb (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_l),
        .ser_en(ser_en), .ser_bit(bit_l), .ser_valid(val_l), .ser_first(first_l),
        .ser_last(last_l), .busy(busy_l), .word_count(wc_l)
    );

    always #5 clk = ~clk;

    // Reference model: a word being emitted (act_word, pos bits already sent) plus the
    // queue of accepted words waiting for the shifter (at most one).
    bit           act_valid;
    logic [W-1:0] act_word;
    int           pos;
    logic [W-1:0] hold_q[$];
    logic [15:0]  wc_exp;

    int n_checks = 0;
    int n_pass   = 0;

    // Captured serial streams (MSB instance shifts in at bottom, LSB instance at top)
    logic [31:0] cap_m;
    logic [31:0] cap_l;
    int          run_len;
    int          max_run;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    endtask

    task automatic model_clear();
        act_valid = 1'b0;
        act_word  = '0;
        pos       = 0;
        hold_q.delete();
        wc_exp    = '0;
    endtask

    // One clock cycle: drive at the falling edge, check mid-cycle, then advance the model
    task automatic cycle(input logic rst, input logic vld, input logic [W-1:0] data,
                         input logic en, output bit accepted);
        bit exp_valid;
        @(negedge clk);
        reset    = rst;
        in_valid = vld;
        in_data  = data;
        ser_en   = en;
        if (rst) model_clear();
        #1;
        exp_valid = act_valid && en;
        check_val("in_ready_m", rdy_m, hold_q.size() == 0);
        check_val("in_ready_l", rdy_l, hold_q.size() == 0);
        check_val("ser_valid_m", val_m, exp_valid);
        check_val("ser_valid_l", val_l, exp_valid);
        check_val("ser_bit_m", bit_m, act_valid ? act_word[W-1-pos] : IDLE_B);
        check_val("ser_bit_l", bit_l, act_valid ? act_word[pos] : IDLE_B);
        check_val("ser_first_m", first_m, exp_valid && pos == 0);
        check_val("ser_last_m", last_m, exp_valid && pos == W-1);
        check_val("ser_first_l", first_l, exp_valid && pos == 0);
        check_val("ser_last_l", last_l, exp_valid && pos == W-1);
        check_val("busy_m", busy_m, act_valid || hold_q.size() != 0);
        check_val("busy_l", busy_l, act_valid || hold_q.size() != 0);
        check_val("word_count_m", wc_m, wc_exp);
        check_val("word_count_l", wc_l, wc_exp);

        if (val_m) begin
            cap_m = {cap_m[30:0], bit_m};
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        if (val_l) cap_l = {bit_l, cap_l[31:1]};

        accepted = 1'b0;
        if (!rst) begin
            accepted = vld && (hold_q.size() == 0);
            if (act_valid && en) begin
                pos++;
                if (pos == W) begin
                    wc_exp++;
                    act_valid = 1'b0;
                    $display("word sent data=%02h count=%0d", act_word, wc_exp);
                end
            end
            if (!act_valid && hold_q.size() != 0) begin
                act_word  = hold_q.pop_front();
                act_valid = 1'b1;
                pos       = 0;
            end
            if (accepted) hold_q.push_back(data);
        end
    endtask

    task automatic idle(input int n, input logic en);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, en, acc);
    endtask

    // Hold in_valid high until the word is taken; a timeout counts as a failure
    task automatic send(input logic [W-1:0] word, input logic en);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 100) begin
            cycle(1'b0, 1'b1, word, en, acc);
            tries++;
        end
        check_val("send_accepted", acc, 1'b1);
    endtask

    task automatic clear_capture();
        cap_m   = '0;
        cap_l   = '0;
        run_len = 0;
        max_run = 0;
    endtask

    initial begin
        bit acc;
        model_clear();
        clear_capture();

        // Reset then idle
        cycle(1'b1, 1'b0, '0, 1'b0, acc);
        cycle(1'b1, 1'b0, '0, 1'b1, acc);
        idle(5, 1'b1);
        check_val("reset_word_count", wc_m, 16'd0);
        check_val("reset_in_ready", rdy_m, 1'b1);

        // Single word D8
        clear_capture();
        send(8'hD8, 1'b1);
        idle(10, 1'b1);
        check_val("d8_stream_msb", cap_m[7:0], 8'hD8);
        check_val("d8_stream_lsb", cap_l[31:24], 8'hD8);
        check_val("d8_run", max_run, 8);

        // Back-to-back A5, 3C
        clear_capture();
        send(8'hA5, 1'b1);
        send(8'h3C, 1'b1);
        idle(20, 1'b1);
        check_val("b2b_stream", cap_m[15:0], 16'hA53C);
        check_val("b2b_run", max_run, 16);

        // F0 with a 3-cycle pause in mid-word
        clear_capture();
        send(8'hF0, 1'b1);
        idle(3, 1'b1);
        idle(3, 1'b0);
        idle(12, 1'b1);
        check_val("pause_stream", cap_m[7:0], 8'hF0);

        // Reset mid-word with a second word buffered
        clear_capture();
        send(8'hFF, 1'b1);
        send(8'h55, 1'b1);
        idle(2, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1, acc);
        idle(12, 1'b1);
        check_val("reset_mid_count", wc_m, 16'd0);
        check_val("reset_mid_novalid", max_run <= 8, 1'b1);

        // LSB-first ordering of 01
        clear_capture();
        send(8'h01, 1'b1);
        idle(10, 1'b1);
        check_val("lsb_01_stream", cap_l[31:24], 8'h01);
        check_val("msb_01_stream", cap_m[7:0], 8'h01);

        // Randomized traffic, enable gaps and occasional resets
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(199) == 0), ($urandom_range(1) == 1),
                  W'($urandom), ($urandom_range(3) != 0), acc);
        end
        idle(30, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
